// File: rtl/mont_product.sv
// mont_product: radix-2 Montgomery multiplier, m = a*b*2^-WIDTH mod N over WIDTH
// serial iterations with a start/finish handshake.
module mont_product #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] m,
  output logic             finish
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, n_r;
  logic [WIDTH+1:0] acc, t1, t2;
  logic [CW-1:0] cnt;
  // acc stays below 2N, so t1/t2 fit in WIDTH+2 bits without overflow
  always_comb begin
    state_n = state == IDLE ? (start ? CALC : IDLE)
            : state == CALC ? (cnt == CW'(WIDTH - 1) ? DONE : CALC)
            : IDLE;
    t1 = acc + (b_r[cnt[CW-2:0]] ? {2'b00, a_r} : '0);
    t2 = t1 + (t1[0] ? {2'b00, n_r} : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      n_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      m      <= '0;
      finish <= 1'b0;
    end else begin
      finish <= state == DONE;
      if (state == IDLE && start) begin
        a_r <= a;
        b_r <= b;
        n_r <= N;
        acc <= '0;
        cnt <= '0;
      end
      if (state == CALC) begin
        acc <= t2 >> 1;
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) m <= WIDTH'(acc >= {2'b00, n_r} ? acc - {2'b00, n_r} : acc);
    end
  end
endmodule

// File: tb/tb_mont_product.sv
// tb_mont_product: scoreboard bench for a 256-bit and an 8-bit instance against a
// modular-inverse reference model.
module tb_mont_product;
  typedef struct {
    logic [255:0] m;
    int           c;
  } exp_t;
  logic clk = 0;
  logic r1 = 0, s1 = 0, f1, r8 = 0, s8 = 0, f8;
  logic [255:0] a1 = 0, b1 = 0, n1 = 0, m1;
  logic [7:0] a8 = 0, b8 = 0, n8 = 0, m8;
  logic [255:0] last1 = 0;
  logic [7:0] last8 = 0;
  exp_t q1[$], q8[$];
  exp_t e1, e8;
  int cyc = 0, checks = 0, failures = 0;
  mont_product u256 (.clk(clk), .rst_n(r1), .start(s1), .N(n1), .a(a1), .b(b1), .m(m1), .finish(f1));
  mont_product #(.WIDTH(8)) u8 (.clk(clk), .rst_n(r8), .start(s8), .N(n8), .a(a8), .b(b8), .m(m8), .finish(f8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  // m = a*b*R^-1 mod N, with R^-1 built from the modular inverse of 2, (N+1)/2
  function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                         input logic [255:0] n, input int w);
    logic [511:0] p, inv, nn;
    nn = {256'b0, n};
    inv = (nn + 1) >> 1;
    p = ({256'b0, a} * {256'b0, b}) % nn;
    for (int i = 0; i < w; i++) p = (p * inv) % nn;
    return p[255:0];
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] r = 0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction
  always @(negedge clk) begin
    if (!r1) last1 = '0;
    else if (f1) begin
      if (q1.size() == 0) chk("unexpected_finish256", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("result256", m1, e1.m);
        chk("latency256", 256'(cyc - e1.c), 256'(258));
      end
      last1 = m1;
    end else chk("stable256", m1, last1);
  end
  always @(negedge clk) begin
    if (!r8) last8 = '0;
    else if (f8) begin
      if (q8.size() == 0) chk("unexpected_finish8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("result8", {248'b0, m8}, e8.m);
        chk("latency8", 256'(cyc - e8.c), 256'(10));
      end
      last8 = m8;
    end else chk("stable8", {248'b0, m8}, {248'b0, last8});
  end
  task automatic go1(input logic [255:0] aa, input logic [255:0] bb, input logic [255:0] nn, input logic [255:0] em);
    @(negedge clk); #1;
    a1 = aa; b1 = bb; n1 = nn; s1 = 1;
    q1.push_back('{em, cyc});
    @(negedge clk); #1;
    s1 = 0;
  endtask
  task automatic go8(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] nn, input logic [255:0] em);
    @(negedge clk); #1;
    a8 = aa; b8 = bb; n8 = nn; s8 = 1;
    q8.push_back('{em, cyc});
    @(negedge clk); #1;
    s8 = 0;
  endtask
  task automatic wait1();
    int k = 0;
    while (q1.size() != 0 && k < 400) begin @(negedge clk); k++; end
    if (q1.size() != 0) begin chk("timeout256", 256'(q1.size()), 0); q1.delete(); end
  endtask
  task automatic wait8();
    int k = 0;
    while (q8.size() != 0 && k < 30) begin @(negedge clk); k++; end
    if (q8.size() != 0) begin chk("timeout8", 256'(q8.size()), 0); q8.delete(); end
  endtask
  task automatic rnd_ops8(output logic [7:0] aa, output logic [7:0] bb, output logic [7:0] nn);
    nn = 8'(2 * $urandom_range(1, 127) + 1);
    aa = 8'($urandom % nn);
    bb = 8'($urandom % nn);
  endtask
  initial begin
    logic [255:0] ra, rb, rn;
    logic [7:0] xa, xb, xn;
    int k;
    #1;
    chk("reset_m256", m1, 0);
    chk("reset_finish256", {255'b0, f1}, 0);
    chk("reset_m8", {248'b0, m8}, 0);
    repeat (3) @(negedge clk);
    #1; r1 = 1; r8 = 1;
    go1(3, 11, 13, 11); wait1();
    go1(9, 1, 13, 3); wait1();
    go1(3, 0, 13, 0); wait1();
    for (int i = 0; i < 4; i++) begin
      rn = rnd256() | {1'b1, 255'b0} | 256'b1;
      ra = rnd256() % rn;
      rb = rnd256() % rn;
      go1(ra, rb, rn, model(ra, rb, rn, 256)); wait1();
    end
    go8(254, 254, 255, 1); wait8();
    go8(12, 12, 13, 3); wait8();
    for (int i = 0; i < 30; i++) begin
      rnd_ops8(xa, xb, xn);
      go8(xa, xb, xn, model({248'b0, xa}, {248'b0, xb}, {248'b0, xn}, 8)); wait8();
    end
    // busy start ignored, and operand changes after the latch have no effect
    rn = rnd256() | 256'b1;
    ra = rnd256() % rn;
    rb = rnd256() % rn;
    go1(ra, rb, rn, model(ra, rb, rn, 256));
    repeat (9) @(negedge clk);
    #1; a1 = 3; b1 = 11; n1 = 13; s1 = 1;
    @(negedge clk); #1; s1 = 0;
    a1 = rnd256(); b1 = rnd256(); n1 = rnd256();
    wait1();
    repeat (300) @(negedge clk);
    // back-to-back with start held high
    @(negedge clk); #1;
    rnd_ops8(xa, xb, xn);
    a8 = xa; b8 = xb; n8 = xn; s8 = 1;
    q8.push_back('{model({248'b0, xa}, {248'b0, xb}, {248'b0, xn}, 8), cyc});
    for (int i = 0; i < 6; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!f8 && k < 30);
      if (!f8) begin chk("timeout_b2b8", 0, 1); break; end
      #1;
      if (i < 5) begin
        rnd_ops8(xa, xb, xn);
        a8 = xa; b8 = xb; n8 = xn;
        q8.push_back('{model({248'b0, xa}, {248'b0, xb}, {248'b0, xn}, 8), cyc});
      end else s8 = 0;
    end
    s8 = 0;
    wait8();
    // reset mid-operation
    go1(5, 7, 13, model(5, 7, 13, 256));
    repeat (99) @(negedge clk);
    #1; r1 = 0; q1.delete();
    #1;
    chk("abort_m256", m1, 0);
    chk("abort_finish256", {255'b0, f1}, 0);
    repeat (3) @(negedge clk);
    #1; r1 = 1;
    repeat (300) @(negedge clk);
    go1(3, 11, 13, 11); wait1();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
